// File: rtl/johnson_phase_sequencer.sv
// Multi-phase enable generator: a 2N-state Johnson ring stepped with a programmable
// per-phase dwell, optional revolution count, graceful stop and illegal-state recovery.
module johnson_phase_sequencer #(
  parameter int N       = 4,
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8,
  localparam int PW     = $clog2(2*N)
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CNT_W-1:0]   cycles,
  output logic [N-1:0]       q,
  output logic [PW-1:0]      phase_idx,
  output logic               step,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [N-1:0]       Q_ZERO    = {N{1'b0}};
  localparam logic [N-1:0]       Q_ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]      PH_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0]      PH_ONE    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]      PH_LAST   = PW'(2*N-1);
  localparam logic [DWELL_W-1:0] DW_ZERO   = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DW_ONE    = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // A legal ring value is thermometer-shaped: {r, ~r[N-1]} has at most one edge.
  function automatic logic ring_legal(input logic [N-1:0] r);
    logic [N:0]   ext;
    logic [N-1:0] diff;
    ext  = {r, ~r[N-1]};
    diff = ext[N:1] ^ ext[N-1:0];
    return ((diff & (diff - Q_ONE)) == Q_ZERO);
  endfunction

  logic [1:0]         state_r, state_s;
  logic [N-1:0]       q_r, q_s;
  logic [PW-1:0]      phase_r, phase_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [DWELL_W-1:0] dcnt_r, dcnt_s;
  logic [CNT_W-1:0]   cycles_r, cycles_s;
  logic [CNT_W-1:0]   rev_r, rev_s;
  logic               step_r, step_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;

  logic [N-1:0]       adv_q_s;
  logic [PW-1:0]      adv_phase_s;
  logic [CNT_W-1:0]   rev_inc_s;
  logic               wrap_s;
  logic               tick_s;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    phase_s     = phase_r;
    dwell_s     = dwell_r;
    dcnt_s      = dcnt_r;
    cycles_s    = cycles_r;
    rev_s       = rev_r;
    step_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = err_r;
    adv_q_s     = {q_r[N-2:0], ~q_r[N-1]};
    wrap_s      = (phase_r == PH_LAST);
    adv_phase_s = wrap_s ? PH_ZERO : (phase_r + PH_ONE);
    rev_inc_s   = rev_r + CNT_ONE;
    tick_s      = (dcnt_r == DW_ZERO);

    case (state_r)
      ST_IDLE: begin
        q_s     = Q_ZERO;
        phase_s = PH_ZERO;
        if (start && !stop) begin
          dwell_s  = dwell;
          cycles_s = cycles;
          dcnt_s   = dwell;
          rev_s    = CNT_ZERO;
          err_s    = 1'b0;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop && (q_r == Q_ZERO)) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else if (tick_s) begin
          q_s     = adv_q_s;
          phase_s = adv_phase_s;
          step_s  = 1'b1;
          dcnt_s  = dwell_r;
          if (wrap_s) begin
            rev_s = rev_inc_s;
            // A stop landing on the final revolution still yields a single done.
            if (stop || ((cycles_r != CNT_ZERO) && (rev_inc_s == cycles_r))) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            state_s = stop ? ST_FLUSH : ST_RUN;
          end
        end else begin
          dcnt_s  = dcnt_r - DW_ONE;
          state_s = stop ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (tick_s) begin
          q_s     = adv_q_s;
          phase_s = adv_phase_s;
          step_s  = 1'b1;
          dcnt_s  = dwell_r;
          if (adv_q_s == Q_ZERO) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_FLUSH;
          end
        end else begin
          dcnt_s  = dcnt_r - DW_ONE;
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
        q_s     = Q_ZERO;
        phase_s = PH_ZERO;
      end
    endcase

    // A corrupted ring restarts from phase 0 without disturbing the control state.
    if (!ring_legal(q_r)) begin
      state_s  = state_r;
      q_s      = Q_ZERO;
      phase_s  = PH_ZERO;
      dwell_s  = dwell_r;
      cycles_s = cycles_r;
      dcnt_s   = dwell_r;
      rev_s    = rev_r;
      step_s   = 1'b0;
      done_s   = 1'b0;
      err_s    = 1'b1;
    end else begin
      err_s    = err_s;
    end

    busy_s = (state_s == ST_RUN) || (state_s == ST_FLUSH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r  <= ST_IDLE;
      q_r      <= Q_ZERO;
      phase_r  <= PH_ZERO;
      dwell_r  <= DW_ZERO;
      dcnt_r   <= DW_ZERO;
      cycles_r <= CNT_ZERO;
      rev_r    <= CNT_ZERO;
      step_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      q_r      <= q_s;
      phase_r  <= phase_s;
      dwell_r  <= dwell_s;
      dcnt_r   <= dcnt_s;
      cycles_r <= cycles_s;
      rev_r    <= rev_s;
      step_r   <= step_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign q         = q_r;
  assign phase_idx = phase_r;
  assign step      = step_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
